// File: rtl/tree_loader_if.sv
// Bus between the byte-stream node programmer, the board UART and the decision-tree node table.
// Latency: none, this is a signal bundle only.
// Backpressure: tx byte is valid/ready; rx is a bare strobe; tree_busy defers the table write.
interface tree_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tree_busy;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       sw_we;
    logic [5:0] sw_addr;
    logic       sw_data_is_leaf;
    logic       sw_data_less_than;
    logic [7:0] sw_data_threshold;
    logic [5:0] sw_data_left_idx;
    logic [5:0] sw_data_right_idx;
    logic [1:0] sw_data_action;
    logic [6:0] nodes_written;
    logic [2:0] err_flags;

    // Loader side: consumes UART bytes and tree status, drives response and node write.
    modport master (
        input  rx_data,
        input  rx_valid,
        input  tree_busy,
        input  tx_ready,
        output tx_data,
        output tx_valid,
        output sw_we,
        output sw_addr,
        output sw_data_is_leaf,
        output sw_data_less_than,
        output sw_data_threshold,
        output sw_data_left_idx,
        output sw_data_right_idx,
        output sw_data_action,
        output nodes_written,
        output err_flags
    );

    // Environment side: UART rx/tx and the decision tree.
    modport slave (
        output rx_data,
        output rx_valid,
        output tree_busy,
        output tx_ready,
        input  tx_data,
        input  tx_valid,
        input  sw_we,
        input  sw_addr,
        input  sw_data_is_leaf,
        input  sw_data_less_than,
        input  sw_data_threshold,
        input  sw_data_left_idx,
        input  sw_data_right_idx,
        input  sw_data_action,
        input  nodes_written,
        input  err_flags
    );
endinterface

// File: rtl/tree_loader.sv
// Assembles 7-byte checksummed node frames from a UART byte stream and writes one node per good frame.
// Latency: sw_we on the cycle after CHK (or first cycle with tree_busy low); ACK the cycle after, NAK the cycle after CHK.
// Backpressure: response held until tx_ready; write deferred by tree_busy; bytes during WRITE/RESP are dropped and flagged.
module tree_loader #(
    parameter int MAX_NODES      = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    tree_loader_if.master bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ADDR   = 4'd1;
    localparam logic [3:0] S_FLAGS  = 4'd2;
    localparam logic [3:0] S_THRESH = 4'd3;
    localparam logic [3:0] S_LEFT   = 4'd4;
    localparam logic [3:0] S_RIGHT  = 4'd5;
    localparam logic [3:0] S_CHK    = 4'd6;
    localparam logic [3:0] S_WRITE  = 4'd7;
    localparam logic [3:0] S_RESP   = 4'd8;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Gap counter only ever needs to hold TIMEOUT_CYCLES-1 idle cycles.
    localparam int             GAP_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic [3:0]       state;
    logic [GAP_W-1:0] gap;
    logic [7:0]       chk_acc;
    logic             field_bad;

    // Frame under reception; only promoted to the node outputs on a good verdict.
    logic [5:0] rx_addr;
    logic [1:0] rx_action;
    logic       rx_is_leaf;
    logic       rx_less_than;
    logic [7:0] rx_threshold;
    logic [5:0] rx_left;
    logic [5:0] rx_right;

    // Node fields presented to the tree's write port.
    logic [5:0] node_addr;
    logic [1:0] node_action;
    logic       node_is_leaf;
    logic       node_less_than;
    logic [7:0] node_threshold;
    logic [5:0] node_left;
    logic [5:0] node_right;

    logic [7:0] tx_byte;
    logic       tx_pending;
    logic [6:0] write_count;
    logic       overrun;
    logic       timed_out;
    logic       frame_bad;

    logic in_frame;
    logic byte_bad;
    logic timeout_hit;
    logic verdict;
    logic frame_good;
    logic write_go;
    logic tx_done;
    logic rx_dropped;

    assign in_frame    = (state >= S_ADDR) && (state <= S_CHK);
    assign timeout_hit = in_frame && !bus.rx_valid && (gap == GAP_LAST);
    assign verdict     = (state == S_CHK) && bus.rx_valid;
    assign frame_good  = !field_bad && (chk_acc == bus.rx_data);
    assign write_go    = (state == S_WRITE) && !bus.tree_busy;
    assign tx_done     = (state == S_RESP) && tx_pending && bus.tx_ready;
    assign rx_dropped  = ((state == S_WRITE) || (state == S_RESP)) && bus.rx_valid;

    // Reserved-bit and address-range check for the byte arriving in the current state.
    always_comb begin
        byte_bad = 1'b0;
        case (state)
            S_ADDR:  byte_bad = ({24'd0, bus.rx_data} >= 32'(MAX_NODES));
            S_FLAGS: byte_bad = |bus.rx_data[7:4];
            S_LEFT:  byte_bad = |bus.rx_data[7:6];
            S_RIGHT: byte_bad = |bus.rx_data[7:6];
            default: byte_bad = 1'b0;
        endcase
    end

    // Frame sequencing: byte-driven advance, timeout abort, write wait and response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR, S_FLAGS, S_THRESH, S_LEFT, S_RIGHT: begin
                    if (bus.rx_valid) begin
                        state <= state + 4'd1;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (verdict) begin
                        state <= frame_good ? S_WRITE : S_RESP;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (write_go) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (tx_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Inter-byte gap: cleared by every accepted byte, counts only while a frame is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= '0;
        end else if (!in_frame || bus.rx_valid || timeout_hit) begin
            gap <= '0;
        end else begin
            gap <= gap + GAP_ONE;
        end
    end

    // Running checksum and bad-field flag, restarted by the sync byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc   <= 8'd0;
            field_bad <= 1'b0;
        end else if ((state == S_IDLE) && bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            chk_acc   <= 8'd0;
            field_bad <= 1'b0;
        end else if (in_frame && (state != S_CHK) && bus.rx_valid) begin
            chk_acc   <= chk_acc ^ bus.rx_data;
            field_bad <= field_bad | byte_bad;
        end
    end

    // Capture the payload bytes of the frame being received.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_addr      <= 6'd0;
            rx_is_leaf   <= 1'b0;
            rx_less_than <= 1'b0;
            rx_action    <= 2'd0;
            rx_threshold <= 8'd0;
            rx_left      <= 6'd0;
            rx_right     <= 6'd0;
        end else if (bus.rx_valid) begin
            case (state)
                S_ADDR: rx_addr <= bus.rx_data[5:0];
                S_FLAGS: begin
                    rx_is_leaf   <= bus.rx_data[0];
                    rx_less_than <= bus.rx_data[1];
                    rx_action    <= bus.rx_data[3:2];
                end
                S_THRESH: rx_threshold <= bus.rx_data;
                S_LEFT:   rx_left      <= bus.rx_data[5:0];
                S_RIGHT:  rx_right     <= bus.rx_data[5:0];
                default: ;
            endcase
        end
    end

    // Promote the captured node on a good verdict so bad frames never disturb the outputs;
    // the fields settle on the edge into WRITE and hold through the sw_we cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_addr      <= 6'd0;
            node_is_leaf   <= 1'b0;
            node_less_than <= 1'b0;
            node_action    <= 2'd0;
            node_threshold <= 8'd0;
            node_left      <= 6'd0;
            node_right     <= 6'd0;
        end else if (verdict && frame_good) begin
            node_addr      <= rx_addr;
            node_is_leaf   <= rx_is_leaf;
            node_less_than <= rx_less_than;
            node_action    <= rx_action;
            node_threshold <= rx_threshold;
            node_left      <= rx_left;
            node_right     <= rx_right;
        end
    end

    // Response byte: NAK straight from the verdict, ACK after the write; held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pending <= 1'b0;
            tx_byte    <= 8'd0;
        end else if (verdict && !frame_good) begin
            tx_pending <= 1'b1;
            tx_byte    <= NAK_BYTE;
        end else if (write_go) begin
            tx_pending <= 1'b1;
            tx_byte    <= ACK_BYTE;
        end else if (tx_done) begin
            tx_pending <= 1'b0;
        end
    end

    // Saturating write count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_count <= 7'd0;
            overrun     <= 1'b0;
            timed_out   <= 1'b0;
            frame_bad   <= 1'b0;
        end else begin
            if (write_go && (write_count != 7'd127)) begin
                write_count <= write_count + 7'd1;
            end
            if (rx_dropped) begin
                overrun <= 1'b1;
            end
            if (timeout_hit) begin
                timed_out <= 1'b1;
            end
            if (verdict && !frame_good) begin
                frame_bad <= 1'b1;
            end
        end
    end

    assign bus.sw_we             = write_go;
    assign bus.sw_addr           = node_addr;
    assign bus.sw_data_is_leaf   = node_is_leaf;
    assign bus.sw_data_less_than = node_less_than;
    assign bus.sw_data_threshold = node_threshold;
    assign bus.sw_data_left_idx  = node_left;
    assign bus.sw_data_right_idx = node_right;
    assign bus.sw_data_action    = node_action;
    assign bus.tx_valid          = tx_pending;
    assign bus.tx_data           = tx_byte;
    assign bus.nodes_written     = write_count;
    assign bus.err_flags         = {overrun, timed_out, frame_bad};
endmodule

// File: tb/tb_tree_loader.sv
// Directed-frame bench for tree_loader with a queue scoreboard for tx bytes and node writes.
// Latency: checks sw_we/tx_valid cycle placement directly around each frame.
// Backpressure: exercises tree_busy deferral, tx_ready stall and overrun.
module tb_tree_loader;
    typedef struct packed {
        logic [5:0] addr;
        logic       leaf;
        logic       lt;
        logic [7:0] th;
        logic [5:0] l;
        logic [5:0] r;
        logic [1:0] act;
    } node_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tree_loader_if bus ();
    tree_loader #(.MAX_NODES(64), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         total = 0;
    int         bad   = 0;
    int         exp_nodes = 0;
    logic [7:0] exp_tx[$];
    node_t      exp_wr[$];
    logic [7:0] mon_byte;
    node_t      mon_node;
    node_t      want;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic node_t cur_node();
        node_t n;
        n.addr = bus.sw_addr;
        n.leaf = bus.sw_data_is_leaf;
        n.lt   = bus.sw_data_less_than;
        n.th   = bus.sw_data_threshold;
        n.l    = bus.sw_data_left_idx;
        n.r    = bus.sw_data_right_idx;
        n.act  = bus.sw_data_action;
        return n;
    endfunction

    function automatic node_t bytes_to_node(input logic [7:0] a, f, t, l, r);
        node_t n;
        n.addr = a[5:0];
        n.leaf = f[0];
        n.lt   = f[1];
        n.act  = f[3:2];
        n.th   = t;
        n.l    = l[5:0];
        n.r    = r[5:0];
        return n;
    endfunction

    // Monitor: pops and compares whenever the DUT presents a transfer or a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected actual=%02h required=none", bus.tx_data);
                end else begin
                    mon_byte = exp_tx.pop_front();
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, mon_byte});
                end
            end
            if (bus.sw_we) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sw_we_unexpected actual=addr %0d required=none", bus.sw_addr);
                end else begin
                    mon_node = exp_wr.pop_front();
                    check("sw_node", {2'b0, cur_node()}, {2'b0, mon_node});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, f, t, l, r, c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(f);
        send_byte(t);
        send_byte(l);
        send_byte(r);
        send_byte(c);
    endtask

    task automatic good_frame(input logic [7:0] a, f, t, l, r);
        exp_wr.push_back(bytes_to_node(a, f, t, l, r));
        exp_tx.push_back(8'h06);
        if (exp_nodes < 127) exp_nodes++;
        send_frame(a, f, t, l, r, a ^ f ^ t ^ l ^ r);
    endtask

    task automatic bad_frame(input logic [7:0] a, f, t, l, r, c);
        exp_tx.push_back(8'h15);
        send_frame(a, f, t, l, r, c);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 100) begin
            step(1);
            n++;
        end
        check(name, exp_tx.size() + exp_wr.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tree_busy = 1'b0;
        bus.tx_ready = 1'b1;
        step(3);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_outputs", {bus.tx_data, bus.sw_we, cur_node(), bus.nodes_written, bus.err_flags}, 0);
        rst = 1'b0;
        step(1);

        // Good frame from the plan, sw_we right after CHK, ACK the cycle after.
        exp_wr.push_back(bytes_to_node(8'h03, 8'h06, 8'h80, 8'h04, 8'h05));
        exp_tx.push_back(8'h06);
        exp_nodes++;
        send_frame(8'h03, 8'h06, 8'h80, 8'h04, 8'h05, 8'h84);
        check("good_sw_we_n1", bus.sw_we, 1);
        step(1);
        check("good_tx_valid_n2", bus.tx_valid, 1);
        drain("good_drain");
        want = '{addr: 6'd3, leaf: 1'b0, lt: 1'b1, th: 8'h80, l: 6'd4, r: 6'd5, act: 2'd1};
        check("good_fields", {2'b0, cur_node()}, {2'b0, want});
        check("good_count", bus.nodes_written, 1);
        check("good_err", bus.err_flags, 3'b000);

        // Checksum mismatch: NAK on N+1, no write, fields untouched.
        bad_frame(8'h03, 8'h06, 8'h80, 8'h04, 8'h05, 8'h85);
        check("badchk_nak_n1", {bus.tx_valid, bus.sw_we, bus.tx_data}, {1'b1, 1'b0, 8'h15});
        drain("badchk_drain");
        check("badchk_err", bus.err_flags, 3'b001);
        check("badchk_fields", {2'b0, cur_node()}, {2'b0, want});

        // Address at MAX_NODES, then reserved FLAGS bit: two NAKs, zero writes.
        bad_frame(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40);
        drain("addr40_drain");
        bad_frame(8'h01, 8'h16, 8'h00, 8'h00, 8'h00, 8'h17);
        drain("flags16_drain");
        check("badfield_count", bus.nodes_written, 1);
        check("badfield_fields", {2'b0, cur_node()}, {2'b0, want});

        // tree_busy high for 10 cycles after CHK, with a stray byte meanwhile.
        bus.tree_busy = 1'b1;
        good_frame(8'h0A, 8'h01, 8'h33, 8'h00, 8'h00);
        check("busy_hold_n1", bus.sw_we, 0);
        send_byte(8'h55);
        step(8);
        check("busy_hold_n10", {bus.sw_we, bus.tx_valid}, 2'b00);
        step(1);
        bus.tree_busy = 1'b0;
        #1;
        check("busy_release_we", bus.sw_we, 1);
        step(1);
        check("busy_tx_after_we", bus.tx_valid, 1);
        drain("busy_drain");
        check("overrun_flag", bus.err_flags, 3'b101);
        check("busy_count", bus.nodes_written, 2);

        // tx_ready low: response held steady, highest legal address accepted.
        bus.tx_ready = 1'b0;
        good_frame(8'h3F, 8'h0C, 8'h01, 8'h02, 8'h03);
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h06});
            step(1);
        end
        bus.tx_ready = 1'b1;
        drain("stall_drain");
        check("stall_count", bus.nodes_written, 3);

        // Gap of 15 idle cycles inside a frame is tolerated.
        exp_wr.push_back(bytes_to_node(8'h01, 8'h02, 8'h03, 8'h04, 8'h05));
        exp_tx.push_back(8'h06);
        exp_nodes++;
        send_byte(8'hA5);
        send_byte(8'h01);
        step(15);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h01);
        drain("gap15_drain");
        check("gap15_err", bus.err_flags, 3'b101);

        // Gap of 16 aborts silently; next frame starts straight away and is ACKed.
        send_byte(8'hA5);
        send_byte(8'h01);
        step(16);
        check("timeout_flag", bus.err_flags, 3'b111);
        check("timeout_no_resp", bus.tx_valid, 0);
        good_frame(8'h02, 8'h00, 8'h44, 8'h01, 8'h02);
        drain("after_timeout_drain");

        // Noise bytes before sync are discarded.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        good_frame(8'h05, 8'h00, 8'h10, 8'h06, 8'h07);
        drain("noise_drain");
        check("noise_count", bus.nodes_written, 7'(exp_nodes));

        // Push the write counter past saturation.
        for (int i = 0; i < 125; i++) begin
            good_frame(8'(i % 64), 8'h03, 8'(i), 8'h01, 8'h02);
            drain("sat_drain");
        end
        check("sat_count", bus.nodes_written, 7'd127);

        // Reset while the ACK is stalled.
        bus.tx_ready = 1'b0;
        exp_wr.push_back(bytes_to_node(8'h09, 8'h00, 8'h00, 8'h00, 8'h00));
        send_frame(8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09);
        step(1);
        check("resp_before_rst", bus.tx_valid, 1);
        rst = 1'b1;
        step(1);
        check("rst_resp_outputs", {bus.tx_valid, bus.nodes_written, bus.err_flags}, 0);
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        exp_nodes = 0;
        drain("rst_resp_drain");

        // Reset mid-frame, then a clean frame still works.
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h08);
        rst = 1'b1;
        step(1);
        check("rst_frame_outputs", {bus.tx_valid, bus.tx_data, bus.sw_we, cur_node(), bus.nodes_written, bus.err_flags}, 0);
        rst = 1'b0;
        step(1);
        good_frame(8'h07, 8'h02, 8'h20, 8'h08, 8'h09);
        drain("post_rst_drain");
        check("post_rst_count", bus.nodes_written, 1);
        check("post_rst_err", bus.err_flags, 3'b000);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
